// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- PC sequencer for the instruction fetch stage.
//
// Generates the registered fetch address (newPC) that IF latches every clock.
// It handles the post-reset boot hold, sequential advance, hazard stalls and
// branch redirects. A 3-deep valid chain (v0 -> v1 -> if_valid) mirrors IF's
// two-cycle latency (pc, then Ins), so downstream logic knows which words
// are genuine. A 2-cycle flush marks the wrong-path words to be squashed
// after a redirect.
//
// Optional feature macro: FETCH_CTRL_PERF_EN (adds fetch_cnt / stall_cnt).
//
// Ports:
//   CLK          in   1  clock, rising edge
//   RST          in   1  asynchronous reset, active-low
//   stall        in   1  hazard request to hold fetch this cycle
//   br_taken     in   1  EX redirect strobe
//   br_target    in  32  redirect byte address
//   newPC        out 32  registered fetch address for IF
//   if_valid     out  1  IF's Ins output this cycle is a genuine fetch
//   flush        out  1  discard the word currently in IF/ID
//   br_misalign  out  1  one-cycle pulse: taken target had bits [1:0] != 0
//   fetch_cnt    out 32  (FETCH_CTRL_PERF_EN) valid, non-stalled fetch edges
//   stall_cnt    out 32  (FETCH_CTRL_PERF_EN) stalled edges outside BOOT
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] newPC,
  output logic        if_valid,
  output logic        flush,
  output logic        br_misalign
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0]  BOOT_LOAD   = 4'(BOOT_CYCLES);
  // Low address bits are forced to zero so a bad parameter can never
  // produce a misaligned fetch.
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_boot_cnt;
  logic [3:0]  w_boot_cnt_nxt;
  logic [31:0] r_new_pc;
  logic [31:0] w_pc_nxt;
  logic        w_redirect;
  logic        w_misalign;
  logic        r_v0;
  logic        r_v1;
  logic        r_if_valid;
  logic        r_flush;
  logic        r_flush_pend;
  logic        r_br_misalign;

  // Next-state, next-PC and redirect decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    w_pc_nxt       = r_new_pc;
    w_redirect     = 1'b0;
    w_misalign     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // Address is held for the whole boot window; stall/br_taken ignored.
        // The <= guards against a zero load value locking the FSM in BOOT.
        w_boot_cnt_nxt = r_boot_cnt - 4'd1;
        if (r_boot_cnt <= 4'd1) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_BOOT;
        end
      end
      ST_RUN, ST_HOLD: begin
        // Redirect wins over stall; with both set the target is loaded and
        // then held.
        if (br_taken) begin
          w_redirect  = 1'b1;
          w_misalign  = |br_target[1:0];
          w_pc_nxt    = {br_target[31:2], 2'b00};
          w_state_nxt = stall ? ST_HOLD : ST_RUN;
        end else if (stall) begin
          w_pc_nxt    = r_new_pc;
          w_state_nxt = ST_HOLD;
        end else begin
          w_pc_nxt    = r_new_pc + 32'd4;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt    = ST_BOOT;
        w_boot_cnt_nxt = BOOT_LOAD;
        w_pc_nxt       = RESET_PC_AL;
      end
    endcase
  end

  // State, boot counter and PC registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= BOOT_LOAD;
      r_new_pc   <= RESET_PC_AL;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_new_pc   <= w_pc_nxt;
    end
  end

  // Valid chain, flush stretcher and misalignment pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_v0          <= 1'b0;
      r_v1          <= 1'b0;
      r_if_valid    <= 1'b0;
      r_flush       <= 1'b0;
      r_flush_pend  <= 1'b0;
      r_br_misalign <= 1'b0;
    end else begin
      if (w_redirect) begin
        // Target enters v0; the two wrong-path words in flight are squashed.
        r_v0         <= 1'b1;
        r_v1         <= 1'b0;
        r_if_valid   <= 1'b0;
        r_flush      <= 1'b1;
        r_flush_pend <= 1'b1;
      end else begin
        // Shifts during stalls too: IF re-reads the held address.
        r_v0         <= (w_state_nxt != ST_BOOT);
        r_v1         <= r_v0;
        r_if_valid   <= r_v1;
        r_flush      <= r_flush_pend;
        r_flush_pend <= 1'b0;
      end
      r_br_misalign <= w_misalign;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (r_if_valid && !stall) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_fetch_cnt <= r_fetch_cnt;
      end
      if (stall && (r_state != ST_BOOT)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  assign newPC       = r_new_pc;
  assign if_valid    = r_if_valid;
  assign flush       = r_flush;
  assign br_misalign = r_br_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- directed self-checking bench for fetch_ctrl
// (RESET_PC = 0, BOOT_CYCLES = 2). Counter checks are compiled in only
// when FETCH_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] newPC;
  logic        if_valid;
  logic        flush;
  logic        br_misalign;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_vec;
  int n_err;

  fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .BOOT_CYCLES (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .newPC       (newPC),
    .if_valid    (if_valid),
    .flush       (flush),
    .br_misalign (br_misalign)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just past it.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    #2;
    n_vec++; if (newPC !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", newPC, 32'h0); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_vec++; if (br_misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", br_misalign); end
`ifdef FETCH_CTRL_PERF_EN
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_boot;
    logic [31:0] exp_pc [0:4];
    logic        exp_v  [0:4];
    exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    exp_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (newPC !== exp_pc[i]) begin n_err++; $display("FAIL boot_pc[%0d]: got %h want %h", i, newPC, exp_pc[i]); end
      n_vec++; if (if_valid !== exp_v[i]) begin n_err++; $display("FAIL boot_valid[%0d]: got %b want %b", i, if_valid, exp_v[i]); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL boot_flush[%0d]: got %b want 0", i, flush); end
    end
  endtask

  task automatic test_stall;
    step();
    n_vec++; if (newPC !== 32'h10) begin n_err++; $display("FAIL stall_pre_pc: got %h want %h", newPC, 32'h10); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (newPC !== 32'h10) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want %h", i, newPC, 32'h10); end
      n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_valid); end
    end
    stall = 1'b0;
    step();
    n_vec++; if (newPC !== 32'h14) begin n_err++; $display("FAIL stall_post_pc: got %h want %h", newPC, 32'h14); end
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_post_valid: got %b want 1", if_valid); end
`ifdef FETCH_CTRL_PERF_EN
    n_vec++; if (stall_cnt !== 32'd3) begin n_err++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
    n_vec++; if (fetch_cnt !== 32'd3) begin n_err++; $display("FAIL fetch_cnt: got %0d want 3", fetch_cnt); end
`endif
  endtask

  task automatic test_redirect;
    logic [31:0] exp_pc [0:2];
    logic        exp_f  [0:2];
    logic        exp_v  [0:2];
    exp_pc = '{32'h100, 32'h104, 32'h108};
    exp_f  = '{1'b1, 1'b1, 1'b0};
    exp_v  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) step();
    n_vec++; if (newPC !== 32'h20) begin n_err++; $display("FAIL redir_pre_pc: got %h want %h", newPC, 32'h20); end
    br_taken = 1'b1; br_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      br_taken = 1'b0;
      n_vec++; if (newPC !== exp_pc[i]) begin n_err++; $display("FAIL redir_pc[%0d]: got %h want %h", i, newPC, exp_pc[i]); end
      n_vec++; if (flush !== exp_f[i]) begin n_err++; $display("FAIL redir_flush[%0d]: got %b want %b", i, flush, exp_f[i]); end
      n_vec++; if (if_valid !== exp_v[i]) begin n_err++; $display("FAIL redir_valid[%0d]: got %b want %b", i, if_valid, exp_v[i]); end
      n_vec++; if (br_misalign !== 1'b0) begin n_err++; $display("FAIL redir_misalign[%0d]: got %b want 0", i, br_misalign); end
    end
  endtask

  task automatic test_branch_stall;
    logic [31:0] exp_pc [0:3];
    logic        exp_f  [0:3];
    logic        exp_v  [0:3];
    exp_pc = '{32'h40, 32'h40, 32'h40, 32'h44};
    exp_f  = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1};
    br_taken = 1'b1; br_target = 32'h40; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      br_taken = 1'b0;
      stall    = (i < 2) ? 1'b1 : 1'b0;
      n_vec++; if (newPC !== exp_pc[i]) begin n_err++; $display("FAIL brstall_pc[%0d]: got %h want %h", i, newPC, exp_pc[i]); end
      n_vec++; if (flush !== exp_f[i]) begin n_err++; $display("FAIL brstall_flush[%0d]: got %b want %b", i, flush, exp_f[i]); end
      n_vec++; if (if_valid !== exp_v[i]) begin n_err++; $display("FAIL brstall_valid[%0d]: got %b want %b", i, if_valid, exp_v[i]); end
    end
`ifdef FETCH_CTRL_PERF_EN
    n_vec++; if (stall_cnt !== 32'd6) begin n_err++; $display("FAIL brstall_stall_cnt: got %0d want 6", stall_cnt); end
`endif
  endtask

  task automatic test_misalign;
    br_taken = 1'b1; br_target = 32'h103;
    step();
    br_taken = 1'b0;
    n_vec++; if (newPC !== 32'h100) begin n_err++; $display("FAIL mis_pc: got %h want %h", newPC, 32'h100); end
    n_vec++; if (br_misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", br_misalign); end
    step();
    n_vec++; if (br_misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", br_misalign); end
    n_vec++; if (newPC !== 32'h104) begin n_err++; $display("FAIL mis_next_pc: got %h want %h", newPC, 32'h104); end
    step();
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL mis_flush_end: got %b want 0", flush); end
  endtask

  task automatic test_back_to_back;
    br_taken = 1'b1; br_target = 32'h200;
    step();
    n_vec++; if (newPC !== 32'h200) begin n_err++; $display("FAIL b2b_pc1: got %h want %h", newPC, 32'h200); end
    br_target = 32'h300;
    step();
    br_taken = 1'b0;
    n_vec++; if (newPC !== 32'h300) begin n_err++; $display("FAIL b2b_pc2: got %h want %h", newPC, 32'h300); end
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL b2b_flush2: got %b want 1", flush); end
    step();
    n_vec++; if (newPC !== 32'h304) begin n_err++; $display("FAIL b2b_pc3: got %h want %h", newPC, 32'h304); end
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL b2b_flush_ext: got %b want 1", flush); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid: got %b want 0", if_valid); end
    // Reset while the flush is still active.
    RST = 1'b0;
    #1;
    n_vec++; if (newPC !== 32'h0) begin n_err++; $display("FAIL midrst_pc: got %h want %h", newPC, 32'h0); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL midrst_flush: got %b want 0", flush); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", if_valid); end
`ifdef FETCH_CTRL_PERF_EN
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    @(negedge CLK);
    RST = 1'b1;
    step();
    n_vec++; if (newPC !== 32'h0) begin n_err++; $display("FAIL rel_pc: got %h want %h", newPC, 32'h0); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL rel_flush: got %b want 0", flush); end
    step();
    n_vec++; if (newPC !== 32'h0) begin n_err++; $display("FAIL rel_pc2: got %h want %h", newPC, 32'h0); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_branch_stall();
    test_misalign();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
